// File: rtl/reg_file_pkg.sv
// rtl/reg_file_pkg.sv - Y86-64 register file shared definitions
// Purpose : register IDs, instruction codes and default widths shared by the
//           register file top and its read-port sub-module.
// Ports   : none (package).
package reg_file_pkg;

   localparam int REG_WIDTH = 64;
   localparam int REG_COUNT = 15;

   localparam logic [3:0] RRAX  = 4'd0;
   localparam logic [3:0] RRCX  = 4'd1;
   localparam logic [3:0] RRDX  = 4'd2;
   localparam logic [3:0] RRBX  = 4'd3;
   localparam logic [3:0] RRSP  = 4'd4;
   localparam logic [3:0] RRBP  = 4'd5;
   localparam logic [3:0] RRSI  = 4'd6;
   localparam logic [3:0] RRDI  = 4'd7;
   localparam logic [3:0] RR8   = 4'd8;
   localparam logic [3:0] RR9   = 4'd9;
   localparam logic [3:0] RR10  = 4'd10;
   localparam logic [3:0] RR11  = 4'd11;
   localparam logic [3:0] RR12  = 4'd12;
   localparam logic [3:0] RR13  = 4'd13;
   localparam logic [3:0] RR14  = 4'd14;
   localparam logic [3:0] RNONE = 4'd15;

   typedef enum logic [3:0] {
      I_HALT   = 4'h0,
      I_NOP    = 4'h1,
      I_RRMOVQ = 4'h2,
      I_IRMOVQ = 4'h3,
      I_RMMOVQ = 4'h4,
      I_MRMOVQ = 4'h5,
      I_OPQ    = 4'h6,
      I_JXX    = 4'h7,
      I_CALL   = 4'h8,
      I_RET    = 4'h9,
      I_PUSHQ  = 4'hA,
      I_POPQ   = 4'hB
   } icode_e;

   // True when an ID names a real, implemented register.
   function automatic logic id_in_range(input logic [3:0] id, input int nregs);
      return (int'(id) < nregs) && (id != RNONE);
   endfunction

endpackage

// File: rtl/reg_file_read_port.sv
// rtl/reg_file_read_port.sv - one combinational register-file read port
// Purpose : decodes a source register ID against the stored array and, when
//           enabled, forwards same-cycle write data (port B over port A).
// Ports   : src_i      source register ID (15 or out of range reads 0)
//           regs_i     stored register array
//           we_i       commit enable of the current cycle
//           dst_a_i/data_a_i, dst_b_i/data_b_i  write requests for bypass
//           val_o      read data
module reg_file_read_port
   import reg_file_pkg::*;
#(
   parameter int WIDTH  = REG_WIDTH,
   parameter int NREGS  = REG_COUNT,
   parameter bit BYPASS = 1'b1
) (
   input  logic [3:0]       src_i,
   input  logic [WIDTH-1:0] regs_i [NREGS],
   input  logic             we_i,
   input  logic [3:0]       dst_a_i,
   input  logic [WIDTH-1:0] data_a_i,
   input  logic [3:0]       dst_b_i,
   input  logic [WIDTH-1:0] data_b_i,
   output logic [WIDTH-1:0] val_o
);

   logic [WIDTH-1:0] stored;
   logic             hit_a;
   logic             hit_b;

   always_comb begin
      // Compare-select instead of direct indexing so IDs >= NREGS fall to 0.
      stored = '0;
      for (int i = 0; i < NREGS; i++) begin
         if (src_i == 4'(i)) begin
            stored = regs_i[i];
         end
      end
   end

   always_comb begin
      hit_a = we_i && id_in_range(dst_a_i, NREGS) && (dst_a_i == src_i);
      hit_b = we_i && id_in_range(dst_b_i, NREGS) && (dst_b_i == src_i);
   end

   always_comb begin
      val_o = stored;
      if (BYPASS) begin
         // B is checked first so popq %rsp forwards the popped value.
         if (hit_b) begin
            val_o = data_b_i;
         end else if (hit_a) begin
            val_o = data_a_i;
         end
      end
   end

endmodule

// File: rtl/reg_file.sv
// rtl/reg_file.sv - Y86-64 architectural register file with dual write-back
// Purpose : holds %rax..%r14, commits two write-back requests per edge (B wins
//           on a shared destination), serves two decode read ports with
//           optional bypass, a non-bypassed debug port and a commit counter.
// Ports   : clk, rst            clock, asynchronous active-high reset
//           wb_valid, halt      commit qualifiers
//           dstA/dataA, dstB/dataB  write requests (ID 15 = none)
//           srcA/valA, srcB/valB    decode read ports
//           dbg_sel/dbg_data        debug read port (stored values only)
//           wr_count                commit edges since reset
module reg_file
   import reg_file_pkg::*;
#(
   parameter int               WIDTH    = REG_WIDTH,
   parameter int               NREGS    = REG_COUNT,
   parameter int               RSP_ID   = 4,
   parameter logic [WIDTH-1:0] RSP_INIT = '0,
   parameter bit               BYPASS   = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wb_valid,
   input  logic             halt,
   input  logic [3:0]       dstA,
   input  logic [WIDTH-1:0] dataA,
   input  logic [3:0]       dstB,
   input  logic [WIDTH-1:0] dataB,
   input  logic [3:0]       srcA,
   input  logic [3:0]       srcB,
   output logic [WIDTH-1:0] valA,
   output logic [WIDTH-1:0] valB,
   input  logic [3:0]       dbg_sel,
   output logic [WIDTH-1:0] dbg_data,
   output logic [31:0]      wr_count
);

   logic [WIDTH-1:0] regs_q [NREGS];
   logic [WIDTH-1:0] regs_d [NREGS];
   logic [31:0]      wr_count_q;
   logic [31:0]      wr_count_d;
   logic             we;
   logic             any_dst;

   // rst is part of the enable so nothing commits on an edge where reset is seen.
   assign we      = wb_valid & ~halt & ~rst;
   assign any_dst = (dstA != RNONE) || (dstB != RNONE);

   always_comb begin
      regs_d = regs_q;
      if (we) begin
         // A first, then B, so B overwrites A on a shared destination.
         for (int i = 0; i < NREGS; i++) begin
            if (id_in_range(dstA, NREGS) && (dstA == 4'(i))) begin
               regs_d[i] = dataA;
            end
         end
         for (int i = 0; i < NREGS; i++) begin
            if (id_in_range(dstB, NREGS) && (dstB == 4'(i))) begin
               regs_d[i] = dataB;
            end
         end
      end
   end

   always_comb begin
      wr_count_d = wr_count_q;
      if (we && any_dst) begin
         wr_count_d = wr_count_q + 32'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NREGS; i++) begin
            regs_q[i] <= (i == RSP_ID) ? RSP_INIT : '0;
         end
         wr_count_q <= '0;
      end else begin
         regs_q     <= regs_d;
         wr_count_q <= wr_count_d;
      end
   end

   assign wr_count = wr_count_q;

   reg_file_read_port #(.WIDTH(WIDTH), .NREGS(NREGS), .BYPASS(BYPASS)) u_port_a (
      .src_i    (srcA),
      .regs_i   (regs_q),
      .we_i     (we),
      .dst_a_i  (dstA),
      .data_a_i (dataA),
      .dst_b_i  (dstB),
      .data_b_i (dataB),
      .val_o    (valA)
   );

   reg_file_read_port #(.WIDTH(WIDTH), .NREGS(NREGS), .BYPASS(BYPASS)) u_port_b (
      .src_i    (srcB),
      .regs_i   (regs_q),
      .we_i     (we),
      .dst_a_i  (dstA),
      .data_a_i (dataA),
      .dst_b_i  (dstB),
      .data_b_i (dataB),
      .val_o    (valB)
   );

   // Debug port shows only committed state.
   reg_file_read_port #(.WIDTH(WIDTH), .NREGS(NREGS), .BYPASS(1'b0)) u_port_dbg (
      .src_i    (dbg_sel),
      .regs_i   (regs_q),
      .we_i     (1'b0),
      .dst_a_i  (RNONE),
      .data_a_i ('0),
      .dst_b_i  (RNONE),
      .data_b_i ('0),
      .val_o    (dbg_data)
   );

endmodule

// File: tb/tb_reg_file.sv
// tb/tb_reg_file.sv - self-checking bench for reg_file
module tb_reg_file;

   localparam logic [63:0] RSP_INIT = 64'h100;

   logic        clk = 1'b0;
   logic        rst;
   logic        wb_valid, halt;
   logic [3:0]  dstA, dstB, srcA, srcB, dbg_sel;
   logic [63:0] dataA, dataB;
   logic [63:0] valA, valB, dbg_data;
   logic [31:0] wr_count;

   int n_chk  = 0;
   int n_pass = 0;

   // Reference state: architectural registers and commit count.
   logic [63:0] mem [15];
   int unsigned commits;

   always #5 clk = ~clk;

   reg_file #(.WIDTH(64), .NREGS(15), .RSP_ID(4), .RSP_INIT(RSP_INIT), .BYPASS(1'b1)) dut (
      .clk      (clk),
      .rst      (rst),
      .wb_valid (wb_valid),
      .halt     (halt),
      .dstA     (dstA),
      .dataA    (dataA),
      .dstB     (dstB),
      .dataB    (dataB),
      .srcA     (srcA),
      .srcB     (srcB),
      .valA     (valA),
      .valB     (valB),
      .dbg_sel  (dbg_sel),
      .dbg_data (dbg_data),
      .wr_count (wr_count)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   task automatic model_reset();
      for (int i = 0; i < 15; i++) mem[i] = (i == 4) ? RSP_INIT : 64'h0;
      commits = 0;
   endtask

   function automatic logic [63:0] stored(input logic [3:0] id);
      if (id >= 4'd15) return 64'h0;
      return mem[id];
   endfunction

   // What decode should see this cycle: pending write data beats stored data, B beats A.
   function automatic logic [63:0] seen(input logic [3:0] id);
      logic commit_now;
      commit_now = wb_valid && !halt;
      if (commit_now && id != 4'd15 && id == dstB) return dataB;
      if (commit_now && id != 4'd15 && id == dstA) return dataA;
      return stored(id);
   endfunction

   task automatic model_commit();
      if (wb_valid && !halt) begin
         if (dstA != 4'd15) mem[dstA] = dataA;
         if (dstB != 4'd15) mem[dstB] = dataB;
         if (dstA != 4'd15 || dstB != 4'd15) commits = commits + 1;
      end
   endtask

   // Called at posedge+1: apply inputs, check reads mid-cycle, clock, check count.
   task automatic step(input string tag, input logic wbv, input logic hlt,
                       input logic [3:0] da, input logic [63:0] xa,
                       input logic [3:0] db, input logic [63:0] xb,
                       input logic [3:0] sa, input logic [3:0] sb, input logic [3:0] ds);
      wb_valid = wbv; halt = hlt;
      dstA = da; dataA = xa; dstB = db; dataB = xb;
      srcA = sa; srcB = sb; dbg_sel = ds;
      #3;
      check({tag, ".valA"}, valA, seen(sa));
      check({tag, ".valB"}, valB, seen(sb));
      check({tag, ".dbg"}, dbg_data, stored(ds));
      @(posedge clk);
      model_commit();
      #1;
      check({tag, ".cnt"}, {32'h0, wr_count}, {32'h0, commits});
   endtask

   task automatic idle();
      wb_valid = 1'b0; halt = 1'b0;
      dstA = 4'd15; dstB = 4'd15; dataA = '0; dataB = '0;
      srcA = 4'd15; srcB = 4'd15; dbg_sel = 4'd0;
   endtask

   initial begin
      rst = 1'b1;
      idle();
      model_reset();
      #12 rst = 1'b0;
      @(posedge clk); #1;

      // 1: reset contents through the debug port
      for (int i = 0; i < 15; i++) begin
         dbg_sel = 4'(i);
         @(negedge clk);
         check("rst.dbg", dbg_data, (i == 4) ? 64'h100 : 64'h0);
      end
      check("rst.cnt", {32'h0, wr_count}, 64'h0);
      @(posedge clk); #1;

      // 2: single port A write, visible next cycle
      step("t2.wr", 1, 0, 4'd3, 64'h55, 4'd15, 64'h0, 4'd15, 4'd15, 4'd3);
      step("t2.rd", 0, 0, 4'd15, 64'h0, 4'd15, 64'h0, 4'd3, 4'd15, 4'd3);
      check("t2.lit.valA", valA, 64'h55);
      check("t2.lit.cnt", {32'h0, wr_count}, 64'd1);

      // 3: popq %rsp - both ports hit reg 4, B wins, bypassed same cycle
      step("t3.pop", 1, 0, 4'd4, 64'h108, 4'd4, 64'hAA, 4'd15, 4'd4, 4'd4);
      step("t3.rd", 0, 0, 4'd15, 64'h0, 4'd15, 64'h0, 4'd4, 4'd15, 4'd4);
      check("t3.lit.valA", valA, 64'hAA);

      // 4: halt and bubble block commits
      step("t4.halt", 1, 1, 4'd2, 64'h77, 4'd15, 64'h0, 4'd2, 4'd15, 4'd2);
      step("t4.bub", 0, 0, 4'd2, 64'h77, 4'd15, 64'h0, 4'd2, 4'd15, 4'd2);
      check("t4.lit.dbg", dbg_data, 64'h0);
      check("t4.lit.cnt", {32'h0, wr_count}, 64'd2);

      // 6: no destinations with undriven data
      step("t6.none", 1, 0, 4'd15, 'x, 4'd15, 'x, 4'd15, 4'd3, 4'd3);
      check("t6.lit.valA", valA, 64'h0);

      // Randomized traffic against the reference model
      for (int n = 0; n < 80; n++) begin
         step("rnd", ($urandom_range(0, 3) != 0), ($urandom_range(0, 4) == 0),
              4'($urandom_range(0, 15)), {$urandom, $urandom},
              4'($urandom_range(0, 15)), {$urandom, $urandom},
              4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
              4'($urandom_range(0, 15)));
      end

      // 5: write pending while reset asserts mid-cycle
      step("t5.pre", 1, 0, 4'd1, 64'h1234, 4'd15, 64'h0, 4'd15, 4'd15, 4'd1);
      wb_valid = 1'b1; halt = 1'b0; dstA = 4'd1; dataA = 64'h11; dstB = 4'd15;
      dbg_sel = 4'd1;
      #2 rst = 1'b1;
      #1;
      model_reset();
      check("t5.async.dbg", dbg_data, 64'h0);
      check("t5.async.cnt", {32'h0, wr_count}, 64'h0);
      @(posedge clk);
      #3 rst = 1'b0; wb_valid = 1'b0;
      #1;
      check("t5.rel.dbg", dbg_data, 64'h0);
      @(posedge clk); #1;
      check("t5.post.dbg", dbg_data, 64'h0);
      check("t5.post.cnt", {32'h0, wr_count}, 64'h0);
      dbg_sel = 4'd4;
      #1 check("t5.post.rsp", dbg_data, 64'h100);

      @(posedge clk); #1;
      for (int n = 0; n < 20; n++) begin
         step("rnd2", ($urandom_range(0, 3) != 0), ($urandom_range(0, 4) == 0),
              4'($urandom_range(0, 15)), {$urandom, $urandom},
              4'($urandom_range(0, 15)), {$urandom, $urandom},
              4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
              4'($urandom_range(0, 15)));
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
